// File: rtl/bus_master_pkg.sv
// Shared types and constants for the bus initiator controller and its address decoder.
package bus_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

  // Slave index occupies the top SLV_IDX_W bits of the address.
  localparam int SLV_IDX_W   = 3;
  localparam int TIMEOUT_DEF = 255;

  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/bus_addr_dec.sv
// Slave index -> one-hot chip enable decoder with an unmapped flag; shared by all initiators.
module bus_addr_dec
  import bus_master_pkg::*;
#(
  parameter int SLV_NUM = 5
) (
  input  logic [SLV_IDX_W-1:0] slv_idx,
  output logic [SLV_NUM-1:0]   c_en,
  output logic                 unmapped
);

  always_comb begin
    c_en = '0;
    for (int k = 0; k < SLV_NUM; k++) begin
      if (slv_idx == SLV_IDX_W'(k)) c_en[k] = 1'b1;
    end
  end

  assign unmapped = ({{(32-SLV_IDX_W){1'b0}}, slv_idx} >= 32'(SLV_NUM));

endmodule

// File: rtl/bus_master_ctrl.sv
// Initiator-side bus controller: one core request -> one decoded slave transaction.
// Optional BUS_TIMEOUT_EN aborts an ACCESS that waits TIMEOUT cycles without ready.
module bus_master_ctrl
  import bus_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SLV_NUM = 5,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic [SLV_NUM-1:0] c_en_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               we_o,
  output logic [DATA_W-1:0]  wr_data_o,
  input  logic [DATA_W-1:0]  rd_data_i,
  input  logic               ready_i
);

  // Handshake: the core holds req_i until done_o/err_o; req_i is only looked at in
  // IDLE. ready_i from the slave mux completes the access in the cycle it is seen
  // high during ACCESS and is ignored in every other state.

  state_t             state, state_d;
  logic [SLV_NUM-1:0] dec_c_en;
  logic               dec_unmapped;
  logic [SLV_NUM-1:0] c_en_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               latch_req;
  logic               capture_rd;
  logic               timeout_hit;

  bus_addr_dec #(.SLV_NUM(SLV_NUM)) u_dec (
    .slv_idx  (addr_i[ADDR_W-1 -: SLV_IDX_W]),
    .c_en     (dec_c_en),
    .unmapped (dec_unmapped)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = cnt_w(TIMEOUT);
  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside ACCESS, so every access starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst || state != ACCESS) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    c_en_d     = c_en_o;
    done_d     = 1'b0;
    err_d      = 1'b0;
    latch_req  = 1'b0;
    capture_rd = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          latch_req = 1'b1;
          if (dec_unmapped) begin
            state_d = ERR;
          end else begin
            state_d = ACCESS;
            c_en_d  = dec_c_en;
          end
        end
      end
      ACCESS: begin
        // ready wins over a coincident timeout.
        if (ready_i) begin
          capture_rd = ~we_o;
          done_d     = 1'b1;
          c_en_d     = '0;
          state_d    = IDLE;
        end else if (timeout_hit) begin
          c_en_d  = '0;
          state_d = ERR;
        end
      end
      ERR: begin
        // Error is reported through a registered flag, aligned with done_o.
        err_d   = 1'b1;
        c_en_d  = '0;
        state_d = IDLE;
      end
      default: begin
        c_en_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      c_en_o    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_o    <= '0;
      we_o      <= 1'b0;
      wr_data_o <= '0;
      rd_data_o <= '0;
    end else begin
      state  <= state_d;
      c_en_o <= c_en_d;
      done_q <= done_d;
      err_q  <= err_d;
      if (latch_req) begin
        addr_o    <= addr_i;
        we_o      <= we_i;
        wr_data_o <= wr_data_i;
      end
      if (capture_rd) rd_data_o <= rd_data_i;
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Self-checking bench for bus_master_ctrl: transaction-level model compared every cycle,
// plus directed literal checks. Honours BUS_TIMEOUT_EN (TIMEOUT=4 when defined).
module tb_bus_master_ctrl;

`ifdef BUS_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic [31:0] rd_data_i = '0;
  logic        ready_i = 1'b0;
  logic        busy_o, done_o, err_o, we_o;
  logic [31:0] rd_data_o, addr_o, wr_data_o;
  logic [4:0]  c_en_o;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  bus_master_ctrl #(.ADDR_W(32), .DATA_W(32), .SLV_NUM(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wr_data_i(wr_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_data_o(rd_data_o), .c_en_o(c_en_o), .addr_o(addr_o), .we_o(we_o),
    .wr_data_o(wr_data_o), .rd_data_i(rd_data_i), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Transaction-level model: which slave is being served, how long it has waited,
  // whether an error report is pending, and what the bus outputs must hold.
  int          m_slave = -1;
  int          m_wait  = 0;
  bit          m_err_pending = 1'b0;
  bit          e_done = 1'b0, e_err = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wr = '0, e_rd = '0;

  always @(posedge clk) begin
    bit nd, ne;
    int idx;
    nd = 1'b0;
    ne = 1'b0;
    if (rst) begin
      m_slave = -1; m_wait = 0; m_err_pending = 1'b0;
      e_we = 1'b0; e_addr = '0; e_wr = '0; e_rd = '0;
    end else if (m_err_pending) begin
      m_err_pending = 1'b0;
      ne = 1'b1;
    end else if (m_slave >= 0) begin
      if (ready_i) begin
        if (!e_we) e_rd = rd_data_i;
        nd = 1'b1;
        m_slave = -1;
      end else if (TO_EN && m_wait == TO) begin
        m_slave = -1;
        m_err_pending = 1'b1;
      end else begin
        m_wait++;
      end
    end else if (req_i) begin
      e_addr = addr_i; e_we = we_i; e_wr = wr_data_i;
      idx = int'(addr_i / 32'h2000_0000);
      if (idx < 5) begin
        m_slave = idx;
        m_wait = 0;
      end else begin
        m_err_pending = 1'b1;
      end
    end
    e_done = nd;
    e_err  = ne;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_busy",    64'(busy_o),    64'(m_slave >= 0 || m_err_pending));
      chk("m_c_en",    64'(c_en_o),    (m_slave >= 0) ? (64'd1 << m_slave) : 64'd0);
      chk("m_done",    64'(done_o),    64'(e_done));
      chk("m_err",     64'(err_o),     64'(e_err));
      chk("m_addr",    64'(addr_o),    64'(e_addr));
      chk("m_we",      64'(we_o),      64'(e_we));
      chk("m_wr_data", 64'(wr_data_o), 64'(e_wr));
      chk("m_rd_data", 64'(rd_data_o), 64'(e_rd));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    req_i = 1'b1; we_i = we; addr_i = addr; wr_data_i = wd;
  endtask

  initial begin
    int busy_cnt;
    // clock / reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_c_en", 64'(c_en_o), 64'd0);
    chk("rst_rd",   64'(rd_data_o), 64'd0);

    // Read s2, ready three cycles after c_en rises
    issue(1'b0, 32'h4000_0010, 32'h0);
    step();
    req_i = 1'b0;
    @(negedge clk); chk("rd_s2_c_en1", 64'(c_en_o), 64'b00100);
    step();
    @(negedge clk); chk("rd_s2_c_en2", 64'(c_en_o), 64'b00100);
    step();
    ready_i = 1'b1; rd_data_i = 32'hDEAD_BEEF;
    @(negedge clk); chk("rd_s2_c_en3", 64'(c_en_o), 64'b00100);
    step();
    ready_i = 1'b0; rd_data_i = 32'h0;
    @(negedge clk);
    chk("rd_s2_done", 64'(done_o), 64'd1);
    chk("rd_s2_data", 64'(rd_data_o), 64'hDEAD_BEEF);
    chk("rd_s2_busy", 64'(busy_o), 64'd0);
    chk("rd_s2_c_en_off", 64'(c_en_o), 64'd0);

    // Write s0, zero wait
    step();
    ready_i = 1'b1; rd_data_i = 32'h5555_AAAA;
    issue(1'b1, 32'h0000_0004, 32'h1234_5678);
    step();
    req_i = 1'b0;
    @(negedge clk);
    chk("wr_s0_c_en", 64'(c_en_o), 64'b00001);
    chk("wr_s0_we",   64'(we_o), 64'd1);
    chk("wr_s0_wd",   64'(wr_data_o), 64'h1234_5678);
    step();
    ready_i = 1'b0;
    @(negedge clk);
    chk("wr_s0_done", 64'(done_o), 64'd1);
    chk("wr_s0_rd_kept", 64'(rd_data_o), 64'hDEAD_BEEF);

    // Unmapped address (idx 7)
    step();
    issue(1'b0, 32'hE000_0000, 32'h0);
    step();
    req_i = 1'b0;
    @(negedge clk);
    chk("unm_c_en", 64'(c_en_o), 64'd0);
    chk("unm_err_early", 64'(err_o), 64'd0);
    step();
    @(negedge clk);
    chk("unm_err", 64'(err_o), 64'd1);
    chk("unm_busy", 64'(busy_o), 64'd0);
    step();
    @(negedge clk);
    chk("unm_err_once", 64'(err_o), 64'd0);

    // Back-to-back: s4 read, then s1 request held through the done cycle
    issue(1'b0, 32'h8000_0000, 32'h0);
    step();
    issue(1'b0, 32'h2000_0000, 32'h0);
    ready_i = 1'b1; rd_data_i = 32'hCAFE_F00D;
    @(negedge clk); chk("b2b_c_en_s4", 64'(c_en_o), 64'b10000);
    step();
    ready_i = 1'b0;
    @(negedge clk);
    chk("b2b_done", 64'(done_o), 64'd1);
    chk("b2b_c_en_gap", 64'(c_en_o), 64'd0);
    chk("b2b_rd", 64'(rd_data_o), 64'hCAFE_F00D);
    step();
    req_i = 1'b0;
    @(negedge clk); chk("b2b_c_en_s1", 64'(c_en_o), 64'b00010);
    ready_i = 1'b1; rd_data_i = 32'h0BAD_0001;
    step();
    ready_i = 1'b0;
    @(negedge clk); chk("b2b_done2", 64'(done_o), 64'd1);

    // Timeout behaviour
    step();
    issue(1'b0, 32'h2000_0000, 32'h0);
    step();
    req_i = 1'b0;
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("to_c_en_hold", 64'(c_en_o), 64'b00010);
      step();
    end
    @(negedge clk);
    chk("to_c_en_off", 64'(c_en_o), 64'd0);
    chk("to_err_early", 64'(err_o), 64'd0);
    step();
    @(negedge clk); chk("to_err", 64'(err_o), 64'd1);
    step();
    issue(1'b0, 32'h2000_0000, 32'h0);
    step();
    req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("to2_c_en_hold", 64'(c_en_o), 64'b00010);
      step();
    end
    ready_i = 1'b1; rd_data_i = 32'h7777_0004;
    @(negedge clk); chk("to2_c_en_last", 64'(c_en_o), 64'b00010);
    step();
    ready_i = 1'b0;
    @(negedge clk);
    chk("to2_done", 64'(done_o), 64'd1);
    chk("to2_no_err", 64'(err_o), 64'd0);
    step();
    @(negedge clk); chk("to2_no_err_late", 64'(err_o), 64'd0);
`else
    busy_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy_o === 1'b1 && err_o === 1'b0) busy_cnt++;
      step();
    end
    chk("nto_busy_1000", 64'(busy_cnt), 64'd1000);
    ready_i = 1'b1; rd_data_i = 32'h7777_0004;
    step();
    ready_i = 1'b0;
    @(negedge clk); chk("nto_done", 64'(done_o), 64'd1);
`endif

    // Reset during a pending s1 read
    step();
    issue(1'b0, 32'h2000_0000, 32'h0);
    step();
    req_i = 1'b0;
    @(negedge clk); chk("rstm_c_en", 64'(c_en_o), 64'b00010);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstm_c_en_off", 64'(c_en_o), 64'd0);
    chk("rstm_busy", 64'(busy_o), 64'd0);
    chk("rstm_done", 64'(done_o), 64'd0);
    chk("rstm_err", 64'(err_o), 64'd0);
    step();
    @(negedge clk);
    chk("rstm_done_late", 64'(done_o), 64'd0);
    chk("rstm_err_late", 64'(err_o), 64'd0);
    issue(1'b0, 32'h0000_0008, 32'h0);
    ready_i = 1'b1; rd_data_i = 32'h1111_2222;
    step();
    req_i = 1'b0;
    step();
    ready_i = 1'b0;
    @(negedge clk);
    chk("rstm_new_done", 64'(done_o), 64'd1);
    chk("rstm_new_rd", 64'(rd_data_o), 64'h1111_2222);
    step();
    @(negedge clk);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
